// File: rtl/cnn_cmd_issue.sv
// cnn_cmd_issue: host register file, instruction FIFO and one-at-a-time issue control for the PE scheduler
module cnn_cmd_issue #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [31:0] instruction_o,
    output logic        instruction_valid_o,
    input  logic        instruction_done_i,
    input  logic        stat_idle_i,
    input  logic        reset_req_i,
    output logic [31:0] gp_o [16],
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM, BUSY} state_t;
    state_t           state_q, state_d;
    logic [31:0]      gp_q [16];
    logic [31:0]      gp_d [16];
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [31:0]      instr_q, instr_d;
    logic             run_q, run_d, irq_en_q, irq_en_d, err_q, err_d;
    logic [CNT_W-1:0] donecnt_q, donecnt_d;
    logic             empty, full, wr, push, pop, ctrl_wr, host_flush, fsm_flush, err_set, done_inc;

    // Pointer difference gives occupancy; the extra pointer bit marks full
    assign count = wptr_q - rptr_q;
    assign empty = count == '0;
    assign full  = count[AW];
    // gp may only change while nothing is in flight or about to issue
    assign avs_waitrequest = avs_write && ((avs_address == 6'h10 && full) ||
                             (avs_address < 6'h10 && (state_q != IDLE || (run_q && !empty))));
    assign wr         = avs_write && !avs_waitrequest;
    assign push       = wr && avs_address == 6'h10;
    assign ctrl_wr    = wr && avs_address == 6'h13;
    assign host_flush = ctrl_wr && avs_writedata[2];
    assign pop        = state_q == IDLE && run_q && !empty && stat_idle_i && !host_flush;

    assign instruction_o       = instr_q;
    assign instruction_valid_o = state_q == ISSUE;
    assign gp_o                = gp_q;
    assign irq_o               = empty && state_q == IDLE && irq_en_q;

    // Host read mux, zero when not reading
    always_comb begin
        avs_readdata = !avs_read ? 32'h0 :
                       avs_address < 6'h10 ? gp_q[avs_address[3:0]] :
                       avs_address == 6'h11 ? {8'h0, 8'(count), 12'h0, err_q, state_q != IDLE, full, empty} :
                       avs_address == 6'h12 ? 32'(donecnt_q) :
                       avs_address == 6'h13 ? {30'h0, irq_en_q, run_q} : 32'h0;
    end

    // Issue FSM: pop, strobe, confirm the scheduler left idle, wait for done
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        fsm_flush = 1'b0;
        err_set   = 1'b0;
        done_inc  = 1'b0;
        case (state_q)
            IDLE: if (pop) begin
                state_d = ISSUE;
                instr_d = mem_q[rptr_q[AW-1:0]];
            end
            ISSUE: state_d = CONFIRM;
            CONFIRM: begin
                state_d   = (reset_req_i || stat_idle_i) ? IDLE : BUSY;
                fsm_flush = reset_req_i;
                err_set   = reset_req_i || stat_idle_i;
            end
            BUSY: begin
                state_d   = (reset_req_i || instruction_done_i) ? IDLE : BUSY;
                fsm_flush = reset_req_i;
                err_set   = reset_req_i;
                done_inc  = !reset_req_i && instruction_done_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file, FIFO pointers and control bits; flush discards everything queued before this cycle
    always_comb begin
        gp_d   = gp_q;
        mem_d  = mem_q;
        if (wr && avs_address < 6'h10)
            gp_d[avs_address[3:0]] = avs_writedata;
        if (push)
            mem_d[wptr_q[AW-1:0]] = avs_writedata;
        wptr_d    = wptr_q + (AW+1)'(push);
        rptr_d    = (host_flush || fsm_flush) ? wptr_q : rptr_q + (AW+1)'(pop);
        run_d     = ctrl_wr ? avs_writedata[0] : run_q;
        irq_en_d  = ctrl_wr ? avs_writedata[1] : irq_en_q;
        err_d     = err_set || (err_q && !(ctrl_wr && avs_writedata[3]));
        donecnt_d = (wr && avs_address == 6'h12) ? '0 : donecnt_q + CNT_W'(done_inc);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gp_q      <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            instr_q   <= '0;
            run_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            err_q     <= 1'b0;
            donecnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gp_q      <= gp_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            instr_q   <= instr_d;
            run_q     <= run_d;
            irq_en_q  <= irq_en_d;
            err_q     <= err_d;
            donecnt_q <= donecnt_d;
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule
